// File: rtl/sqrt2_host.sv
// Request/response sequencer for the half-precision square-root unit: loads the
// operand over the shared bus, waits for RESULT (or times out) and returns the result.
module sqrt2_host #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_DATA,
    output logic        OUT_NAN,
    output logic        OUT_PINF,
    output logic        OUT_NINF,
    output logic        OUT_TIMEOUT,
    output logic        BUSY,
    inout  wire  [15:0] SQ_DATA,
    output logic        SQ_ENABLE,
    input  logic        SQ_RESULT,
    input  logic        SQ_IS_NAN,
    input  logic        SQ_IS_PINF,
    input  logic        SQ_IS_NINF
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_e;

    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_FIRST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_VALID   = CNT_W'(2);
    localparam logic [15:0]      TIMEOUT_NAN = 16'h7E00;

    state_e           state_q, state_d;
    logic [15:0]      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             out_nan_q, out_nan_d;
    logic             out_pinf_q, out_pinf_d;
    logic             out_ninf_q, out_ninf_d;
    logic             out_timeout_q, out_timeout_d;
    logic             drive_q, drive_d;
    logic             enable_q, enable_d;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_nan_d     = out_nan_q;
        out_pinf_d    = out_pinf_q;
        out_ninf_d    = out_ninf_q;
        out_timeout_d = out_timeout_q;
        drive_d       = drive_q;
        enable_d      = enable_q;

        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    op_d     = IN_DATA;
                    drive_d  = 1'b1;
                    enable_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                drive_d = 1'b0;
                cnt_d   = CNT_FIRST;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
                // Early RESULT is ignored: the unit only drives the bus from its second cycle.
                if (cnt_q >= CNT_VALID && SQ_RESULT) begin
                    out_data_d    = SQ_DATA;
                    out_nan_d     = SQ_IS_NAN;
                    out_pinf_d    = SQ_IS_PINF;
                    out_ninf_d    = SQ_IS_NINF;
                    out_timeout_d = 1'b0;
                    enable_d      = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CNT_TIMEOUT) begin
                    out_data_d    = TIMEOUT_NAN;
                    out_nan_d     = 1'b1;
                    out_pinf_d    = 1'b0;
                    out_ninf_d    = 1'b0;
                    out_timeout_d = 1'b1;
                    enable_d      = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            op_q          <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_nan_q     <= 1'b0;
            out_pinf_q    <= 1'b0;
            out_ninf_q    <= 1'b0;
            out_timeout_q <= 1'b0;
            drive_q       <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_nan_q     <= out_nan_d;
            out_pinf_q    <= out_pinf_d;
            out_ninf_q    <= out_ninf_d;
            out_timeout_q <= out_timeout_d;
            drive_q       <= drive_d;
            enable_q      <= enable_d;
        end
    end

    // Bus drive and ENABLE come straight from flops so they cannot glitch.
    assign SQ_DATA     = drive_q ? op_q : 16'hzzzz;
    assign SQ_ENABLE   = enable_q;
    assign IN_READY    = (state_q == IDLE);
    assign BUSY        = (state_q != IDLE);
    assign OUT_VALID   = (state_q == RESP);
    assign OUT_DATA    = out_data_q;
    assign OUT_NAN     = out_nan_q;
    assign OUT_PINF    = out_pinf_q;
    assign OUT_NINF    = out_ninf_q;
    assign OUT_TIMEOUT = out_timeout_q;

endmodule

// File: doc/sqrt2_host.md
Name: sqrt2_host

Overview:
- Upstream/downstream sequencer for the half-precision square-root unit (sqrt2).
- Accepts an FP16 operand on a valid/ready request port and owns the unit's ENABLE.
- Drives the operand onto the shared bidirectional 16-bit data bus for the load cycle, then releases it, waits for RESULT, and captures the unit's bus output and flags.
- Returns the captured result on a valid/ready response port, with a timeout guard against a hung unit.

Parameters:
TIMEOUT_CYCLES, 32, WAIT-state cycle limit before abort (range 3..255)
CNT_W, 8, width of the internal wait counter

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  reset, asynchronous, active-low
IN_VALID  input  1  request valid
IN_READY  output  1  request ready (high only in IDLE)
IN_DATA  input  16  FP16 operand
OUT_VALID  output  1  response valid
OUT_READY  input  1  response ready
OUT_DATA  output  16  FP16 result
OUT_NAN  output  1  captured IS_NAN
OUT_PINF  output  1  captured IS_PINF
OUT_NINF  output  1  captured IS_NINF
OUT_TIMEOUT  output  1  response produced by timeout, not by the unit
BUSY  output  1  high in any state other than IDLE
SQ_DATA  inout  16  shared bus to the unit's IO_DATA
SQ_ENABLE  output  1  to the unit's ENABLE
SQ_RESULT  input  1  from the unit's RESULT
SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF  input  1 each  unit flags

Behaviour:
- Reset (async, RST_N=0):
  - State is IDLE; op_reg and wait counter are 0.
  - All OUT_* registers are 0; OUT_VALID=0.
  - SQ_ENABLE=0 and SQ_DATA is high-Z.
  - These values apply immediately, including mid-operation.
- States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - IN_READY=1, SQ_ENABLE=0, SQ_DATA=Z.
  - On an edge with IN_VALID=1: op_reg<=IN_DATA, go to LOAD.
- LOAD (exactly 1 cycle):
  - SQ_DATA driven with op_reg; SQ_ENABLE=1.
  - The unit captures the operand on this edge.
  - Next state WAIT; wait counter<=1.
- WAIT:
  - SQ_ENABLE=1; SQ_DATA=Z. The one-cycle gap before the unit drives the bus (from its counter value 2) guarantees no contention.
  - Wait counter increments each edge and saturates.
  - Capture edge: wait counter>=2 and SQ_RESULT=1.
    - OUT_DATA<=SQ_DATA; OUT_NAN/PINF/NINF<=SQ_IS_* flags; OUT_TIMEOUT<=0; go to RESP.
  - Timeout: otherwise, if wait counter==TIMEOUT_CYCLES.
    - OUT_DATA<=16'h7E00; OUT_NAN<=1; OUT_PINF<=0; OUT_NINF<=0; OUT_TIMEOUT<=1; go to RESP.
  - SQ_RESULT while wait counter<2 is ignored: the bus is not yet valid for special-case bypass results.
- RESP:
  - SQ_ENABLE=0, so the unit self-clears; it is guaranteed at least one low edge.
  - OUT_VALID=1; OUT_* held stable until the handshake.
  - On an edge with OUT_READY=1: go to IDLE.
  - IN_VALID is ignored in RESP.
- Latency:
  - Special cases (0, NaN, negative, +Inf): OUT_VALID rises 3 edges after the accept edge.
  - Normal operand: about 14 edges after LOAD, set by the unit.
  - Back-to-back: the next accept is no earlier than 1 cycle after the response handshake, so SQ_ENABLE is low for at least 2 edges between operations.
- The SQ_DATA output enable is a registered state decode (LOAD only), glitch-free.

Test Plan:
1. IN_DATA=16'h4400 (4.0) with the real sqrt2 attached -> OUT_DATA=16'h4000; OUT_NAN/PINF/NINF=0; OUT_TIMEOUT=0; SQ_DATA driven only during the LOAD cycle.
2. IN_DATA=16'h0000 -> OUT_DATA=16'h0000; flags 0; OUT_VALID high 3 edges after accept. Repeat with 16'h7C00 -> OUT_DATA=16'h7C00, OUT_PINF=1.
3. IN_DATA=16'hBC00 (-1.0) -> OUT_DATA=16'hFE00, OUT_NAN=1; IN_DATA=16'h7D00 -> OUT_DATA=16'h7F00, OUT_NAN=1.
4. OUT_READY held 0 for 6 cycles after OUT_VALID -> OUT_DATA and flags stable; IN_READY=0; SQ_ENABLE=0. A second request is accepted only after the handshake, with the correct result for 16'h4C00 -> 16'h4400.
5. Stub unit with SQ_RESULT stuck 0, TIMEOUT_CYCLES=8 -> OUT_VALID after 8 WAIT cycles; OUT_DATA=16'h7E00, OUT_TIMEOUT=1, OUT_NAN=1.
6. RST_N pulsed low in mid-WAIT -> SQ_ENABLE=0, SQ_DATA=Z and OUT_VALID=0 without waiting for an edge. After release, a new 16'h4400 request completes correctly with 16'h4000.
